// File: rtl/sm_uart_pkg.sv
// Shared types and helpers for the UART ROM loader.
package sm_uart_pkg;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_e;

  // Bytes packed into one instruction word, little-endian.
  localparam int unsigned BYTES_PER_WORD = 4;

  // Clock cycles per serial bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sm_uart_rx.sv
// 8N1 UART receiver: input synchronizer, bit timing and framing FSM.
module sm_uart_rx
  import sm_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

  logic [1:0]       sync_q;
  logic             rx_s;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  // Framing FSM with registered byte and error outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rx_s) state_q <= StStart;
        end
        StStart: begin
          // Recheck mid start bit so short glitches are rejected.
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= rx_s ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              byte_data  <= shift_q;
              byte_valid <= 1'b1;
              state_q    <= StIdle;
            end else begin
              frame_err <= 1'b1;
              state_q   <= StWaitIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitIdle: begin
          // Break condition: wait for the line to return high.
          if (rx_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: rtl/sm_uart_rom_loader.sv
// Packs UART bytes into 32-bit words and writes them into instruction memory.
module sm_uart_rom_loader
  import sm_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100000000,
  parameter int unsigned BAUD           = 115200,
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clkIn,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic              enable,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_wa,
  output logic [31:0]       im_wd,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       LAST_SLOT = 2'(BYTES_PER_WORD - 1);

  logic             rx_frame_err;
  logic             rx_busy;
  logic [1:0]       idx_q;
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_expire;
  logic [1:0]       slot;

  sm_uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk_in     (clkIn),
    .rst_n      (rst_n),
    .rx         (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (rx_frame_err),
    .busy       (rx_busy)
  );

  // A byte landing on the expiry cycle starts a fresh word at slot 0.
  always_comb begin
    tmo_expire = (idx_q != 2'd0) && (tmo_q == TMO_LAST);
    slot       = tmo_expire ? 2'd0 : idx_q;
  end

  // Word assembler, address counter, inter-byte timeout and sticky error.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      tmo_q     <= '0;
      im_we     <= 1'b0;
      im_wa     <= '0;
      im_wd     <= '0;
      frame_err <= 1'b0;
    end else if (!enable) begin
      idx_q     <= '0;
      tmo_q     <= '0;
      im_we     <= 1'b0;
      im_wa     <= '0;
      frame_err <= 1'b0;
    end else begin
      im_we <= 1'b0;
      if (rx_frame_err) frame_err <= 1'b1;
      // Address advances the cycle after the write strobe.
      if (im_we) im_wa <= im_wa + 1'b1;
      if (byte_valid) begin
        im_wd[{slot, 3'b000} +: 8] <= byte_data;
        idx_q <= slot + 2'd1;
        tmo_q <= '0;
        if (slot == LAST_SLOT) im_we <= 1'b1;
      end else if (tmo_expire) begin
        idx_q <= '0;
        tmo_q <= '0;
      end else if (idx_q != 2'd0) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  assign busy = rx_busy || (idx_q != 2'd0);

endmodule

// File: tb/tb_sm_uart_rom_loader.sv
// Directed bench for sm_uart_rom_loader at DIV=10, TIMEOUT_CYCLES=500, ADDR_W=2.
module tb_sm_uart_rom_loader;

  localparam int unsigned ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              uart_rx = 1'b1;
  logic              enable = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_wa;
  logic [31:0]       im_wd;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              frame_err;
  logic              busy;

  int unsigned checks = 0;
  int unsigned passed = 0;

  logic [7:0]        rx_log[$];
  logic [31:0]       wd_log[$];
  logic [ADDR_W-1:0] wa_log[$];

  always #5 clk = ~clk;

  sm_uart_rom_loader #(
    .CLK_HZ         (1000000),
    .BAUD           (100000),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (500)
  ) dut (
    .clkIn      (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .enable     (enable),
    .im_we      (im_we),
    .im_wa      (im_wa),
    .im_wd      (im_wd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Record received bytes and memory writes away from the active edge.
  always @(negedge clk) begin
    if (byte_valid) rx_log.push_back(byte_data);
    if (im_we) begin
      wd_log.push_back(im_wd);
      wa_log.push_back(im_wa);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_len);
    uart_rx = 1'b0;
    idle(10);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(10);
    end
    uart_rx = stop;
    idle(stop_len);
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, 10);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " im_we"}, 32'(im_we), 32'd0);
    check({tag, " im_wa"}, 32'(im_wa), 32'd0);
    check({tag, " im_wd"}, im_wd, 32'd0);
    check({tag, " byte_valid"}, 32'(byte_valid), 32'd0);
    check({tag, " byte_data"}, 32'(byte_data), 32'd0);
    check({tag, " frame_err"}, 32'(frame_err), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int n;
    logic [ADDR_W-1:0] exp_wa[4];
    exp_wa[0] = 2'd1;
    exp_wa[1] = 2'd2;
    exp_wa[2] = 2'd3;
    exp_wa[3] = 2'd0;

    // Reset state.
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);
    enable = 1'b1;
    idle(2);

    // One word, little-endian.
    send_word(32'h12345678);
    idle(5);
    check("word bytes", rx_log.size(), 4);
    check("word b0", 32'(rx_log[0]), 32'h78);
    check("word b1", 32'(rx_log[1]), 32'h56);
    check("word b2", 32'(rx_log[2]), 32'h34);
    check("word b3", 32'(rx_log[3]), 32'h12);
    check("word writes", wd_log.size(), 1);
    check("word addr", 32'(wa_log[0]), 32'd0);
    check("word data", wd_log[0], 32'h12345678);
    check("word next addr", 32'(im_wa), 32'd1);
    check("word busy", 32'(busy), 32'd0);

    // Four more words wrap the 2-bit address.
    for (int w = 1; w < 5; w++) send_word(32'(32'h11111111 * w));
    idle(5);
    check("wrap writes", wd_log.size(), 5);
    for (int i = 0; i < 4; i++) check("wrap addr", 32'(wa_log[i+1]), 32'(exp_wa[i]));
    check("wrap last data", wd_log[4], 32'h44444444);
    check("wrap next addr", 32'(im_wa), 32'd1);

    // False start: 3-cycle low glitch.
    base = rx_log.size();
    uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    check("glitch busy high", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 6) begin
      idle(1);
      n++;
    end
    check("glitch busy low", 32'(busy), 32'd0);
    idle(20);
    check("glitch no byte", rx_log.size(), base);

    // Framing error: stop bit low, line held low 20 more cycles.
    base = rx_log.size();
    send_byte(8'hA5, 1'b0, 30);
    idle(5);
    check("ferr no byte", rx_log.size(), base);
    check("ferr set", 32'(frame_err), 32'd1);
    send_word(32'h44332211);
    idle(5);
    check("ferr writes", wd_log.size(), 6);
    check("ferr addr", 32'(wa_log[5]), 32'd1);
    check("ferr data", wd_log[5], 32'h44332211);
    check("ferr sticky", 32'(frame_err), 32'd1);
    enable = 1'b0;
    idle(2);
    check("disable ferr", 32'(frame_err), 32'd0);
    check("disable addr", 32'(im_wa), 32'd0);

    // Timeout drops a partial word.
    enable = 1'b1;
    idle(2);
    send_byte(8'hAA, 1'b1, 10);
    send_byte(8'hBB, 1'b1, 10);
    idle(5);
    check("tmo pending", 32'(busy), 32'd1);
    idle(600);
    check("tmo dropped", 32'(busy), 32'd0);
    send_word(32'h04030201);
    idle(5);
    check("tmo writes", wd_log.size(), 7);
    check("tmo addr", 32'(wa_log[6]), 32'd0);
    check("tmo data", wd_log[6], 32'h04030201);

    // Enable dropped mid-word; byte while disabled is ignored.
    send_byte(8'hDE, 1'b1, 10);
    send_byte(8'hAD, 1'b1, 10);
    send_byte(8'hBE, 1'b1, 10);
    idle(5);
    enable = 1'b0;
    idle(2);
    check("en drop busy", 32'(busy), 32'd0);
    base = rx_log.size();
    send_byte(8'h5A, 1'b1, 10);
    idle(5);
    check("en low byte seen", rx_log.size(), base + 1);
    check("en low byte data", 32'(byte_data), 32'h5A);
    check("en low no write", wd_log.size(), 7);
    enable = 1'b1;
    idle(2);
    send_word(32'hC3C2C1C0);
    idle(5);
    check("en rise writes", wd_log.size(), 8);
    check("en rise addr", 32'(wa_log[7]), 32'd0);
    check("en rise data", wd_log[7], 32'hC3C2C1C0);

    // Reset mid-byte.
    uart_rx = 1'b0;
    idle(10);
    uart_rx = 1'b1;
    idle(10);
    uart_rx = 1'b0;
    idle(10);
    check("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    #1;
    check_all_zero("midreset");
    idle(3);
    rst_n = 1'b1;
    idle(3);
    base = rx_log.size();
    send_byte(8'h3C, 1'b1, 10);
    idle(5);
    check("post-reset byte", rx_log.size(), base + 1);
    check("post-reset data", 32'(byte_data), 32'h3C);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
